imem_loader: RTL
================

Name: imem_loader

Overview:
- Writer-side counterpart of the processor's instruction-memory read path: receives a byte-stream program image and writes 32-bit words into the instruction memory's write port.
- Holds the processor in reset (cpu_hold) while loading.
- Sits between a byte source (serial receiver, byte valid/ready) and the IM write port.
- The processor's PC/IM read path is unchanged.

Parameters:
- ADDR_WIDTH, 32, width of IMEM_wr_addr (byte address).
- BASE_ADDR, 0, byte address of the first loaded word; must be word-aligned.
- MAX_WORDS, 256, largest accepted word count; larger counts are an error.
- TIMEOUT_CYCLES, 1000000, idle cycles allowed between bytes mid-load before error; counter is 32 bit.

Ports:
- SYS_clk  input  1  system clock.
- SYS_reset  input  1  asynchronous, active-low reset.
- load_start  input  1  single-cycle pulse that begins a load.
- byte_data  input  8  incoming byte.
- byte_valid  input  1  byte_data is valid.
- byte_ready  output  1  loader accepts a byte; a transfer occurs on a cycle with byte_valid=1 and byte_ready=1.
- IMEM_wr_en  output  1  one-cycle IM write strobe.
- IMEM_wr_addr  output  ADDR_WIDTH  IM byte address of the write.
- IMEM_wr_data  output  32  instruction word.
- cpu_hold  output  1  processor reset request, active-high.
- load_done  output  1  one-cycle pulse on successful load.
- load_error  output  1  sticky error flag.

Behaviour:
- Reset (SYS_reset=0, asynchronous):
  - State IDLE.
  - All outputs 0.
  - Counters, checksum and word buffer cleared.
  - A reset mid-load abandons the load; words already written stay in IM.
- Image format:
  - Length high byte, then length low byte: N, 16-bit big-endian word count.
  - N*4 payload bytes, each word MSB first.
  - One checksum byte: XOR of both length bytes and all payload bytes.
- States:
  - IDLE: byte_ready=0, cpu_hold=0. load_start -> LEN_HI; word index, byte count and checksum cleared.
  - LEN_HI: byte_ready=1, cpu_hold=1. Transfer -> LEN_LO.
  - LEN_LO: byte_ready=1, cpu_hold=1. Transfer:
    - N=0 -> CHECK.
    - N>MAX_WORDS -> ERROR.
    - Otherwise -> DATA.
  - DATA: byte_ready=1, cpu_hold=1.
    - Bytes shift into the word buffer MSB first.
    - On the 4th byte transfer of a word, IMEM_wr_en=1 in the next cycle, with IMEM_wr_addr=BASE_ADDR+4*word_idx and IMEM_wr_data=the assembled word. word_idx then increments.
    - After word N-1's 4th byte -> CHECK.
    - byte_ready stays 1 during the write cycle; a byte accepted in that cycle starts the next word.
  - CHECK: byte_ready=1, cpu_hold=1. Transfer:
    - Byte equals the running XOR -> DONE.
    - Otherwise -> ERROR.
  - DONE: one cycle; load_done=1, cpu_hold=1 -> IDLE.
  - ERROR: byte_ready=0, cpu_hold=1, load_error=1, held. load_start -> LEN_HI and clears load_error in the same edge.
- load_start: ignored in LEN_HI, LEN_LO, DATA, CHECK and DONE.
- Timeout:
  - Counter runs in LEN_HI, LEN_LO, DATA and CHECK.
  - Cleared on every transfer and on entry to LEN_HI.
  - Reaching TIMEOUT_CYCLES with no transfer -> ERROR.
  - A transfer in the same cycle as timeout wins; no error.
- Address arithmetic: wraps modulo 2^ADDR_WIDTH; not checked.
- Checksum failure: writes already performed are not rolled back. cpu_hold stays 1, so the corrupt image never executes.
- IMEM_wr_en is never asserted outside the cycle after a word's 4th transfer.

Decomposition:
- imem_loader_pkg:
  - State enum: IDLE, LEN_HI, LEN_LO, DATA, CHECK, DONE, ERROR.
  - Byte-per-word constant (4).
  - Length width (16).
- One natural sub-module: byte_packer. It holds the 4-byte shift register and 2-bit byte counter, and emits word_valid plus a 32-bit word on the 4th byte.
- FSM, checksum and timeout logic stay in imem_loader.

Test Plan:
- Normal load:
  - Stimulus: load_start, then bytes 00 02 20 08 00 05 01 09 50 20 57, valid every cycle.
  - Required: writes (0x0, 0x20080005) and (0x4, 0x01095020); load_done pulses once; cpu_hold falls on the cycle after DONE; load_error=0.
- Bad checksum:
  - Stimulus: same stream with last byte 0x56.
  - Required: both writes occur; ERROR entered; load_error=1 and cpu_hold=1 held; a second load_start clears load_error and raises byte_ready.
- Oversize and zero length:
  - Stimulus: length 0x0101 with MAX_WORDS=256.
  - Required: ERROR right after the length low byte, with no write.
  - Stimulus: length 0x0000 then checksum 0x00.
  - Required: load_done with no write.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=16; stall byte_valid for 16 cycles after 2 payload bytes.
  - Required: ERROR, IMEM_wr_en never asserted.
  - Stimulus: stall for 15 cycles, then continue.
  - Required: normal completion.
- Back-pressure, gaps and ignored start:
  - Stimulus: random byte_valid gaps; load_start pulses mid-DATA.
  - Required: identical writes and ordering to the normal-load case; start pulses ignored.
- Reset mid-DATA:
  - Stimulus: SYS_reset=0 mid-DATA, asynchronous to the clock.
  - Required: outputs 0 immediately, state IDLE, cpu_hold=0; a subsequent full load succeeds.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory image loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLenHi,
        StLenLo,
        StData,
        StCheck,
        StDone,
        StError
    } state_e;

    localparam int unsigned BytesPerWord = 4;
    localparam int unsigned LenWidth     = 16;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Assembles four consecutive bytes (MSB first) into a 32-bit word and flags
// the transfer that completes it.
module imem_loader_byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clear_i,
    input  logic        valid_i,
    input  logic [7:0]  byte_i,
    output logic        word_valid_o,
    output logic [31:0] word_o
);

    localparam logic [1:0] LastIdx = 2'(BytesPerWord - 1);

    logic [1:0]  cnt_q, cnt_d;
    logic [23:0] shift_q, shift_d;

    always_comb begin
        cnt_d   = cnt_q;
        shift_d = shift_q;
        if (clear_i) begin
            cnt_d   = '0;
            shift_d = '0;
        end else if (valid_i) begin
            cnt_d   = cnt_q + 2'd1;
            shift_d = {shift_q[15:0], byte_i};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q   <= '0;
            shift_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

    // The fourth byte is taken straight from the input, so the word is ready
    // on the same edge that accepts it.
    assign word_valid_o = valid_i && !clear_i && (cnt_q == LastIdx);
    assign word_o       = {shift_q, byte_i};

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed, XOR-checksummed byte image into instruction memory
// while holding the processor in reset.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned BASE_ADDR      = 0,
    parameter int unsigned MAX_WORDS      = 256,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic                  SYS_clk,
    input  logic                  SYS_reset,
    input  logic                  load_start,
    input  logic [7:0]            byte_data,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    output logic                  IMEM_wr_en,
    output logic [ADDR_WIDTH-1:0] IMEM_wr_addr,
    output logic [31:0]           IMEM_wr_data,
    output logic                  cpu_hold,
    output logic                  load_done,
    output logic                  load_error
);

    localparam logic [ADDR_WIDTH-1:0] BaseAddr = ADDR_WIDTH'(BASE_ADDR);

    state_e                state_q, state_d;
    logic [7:0]            len_hi_q, len_hi_d;
    logic [LenWidth-1:0]   n_q, n_d;
    logic [LenWidth-1:0]   idx_q, idx_d;
    logic [7:0]            csum_q, csum_d;
    logic [31:0]           tmo_q, tmo_d;
    logic                  wr_en_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]           wr_data_q, wr_data_d;

    logic                  xfer;
    logic                  start_load;
    logic                  pk_valid;
    logic                  pk_word_valid;
    logic [31:0]           pk_word;
    logic [LenWidth-1:0]   len_rx;

    assign byte_ready = (state_q == StLenHi) || (state_q == StLenLo) ||
                        (state_q == StData)  || (state_q == StCheck);
    assign xfer       = byte_valid && byte_ready;
    assign len_rx     = {len_hi_q, byte_data};
    assign start_load = load_start && ((state_q == StIdle) || (state_q == StError));
    assign pk_valid   = xfer && (state_q == StData);

    imem_loader_byte_packer u_packer (
        .clk_i        (SYS_clk),
        .rst_ni       (SYS_reset),
        .clear_i      (start_load),
        .valid_i      (pk_valid),
        .byte_i       (byte_data),
        .word_valid_o (pk_word_valid),
        .word_o       (pk_word)
    );

    always_comb begin
        state_d  = state_q;
        len_hi_d = len_hi_q;
        n_d      = n_q;
        idx_d    = idx_q;
        csum_d   = csum_q;
        tmo_d    = tmo_q;

        // Idle-cycle counter only runs while waiting on the byte source.
        if (byte_ready) begin
            tmo_d = xfer ? 32'd0 : tmo_q + 32'd1;
        end

        unique case (state_q)
            StIdle: ;
            StLenHi: begin
                if (xfer) begin
                    len_hi_d = byte_data;
                    csum_d   = csum_q ^ byte_data;
                    state_d  = StLenLo;
                end
            end
            StLenLo: begin
                if (xfer) begin
                    n_d    = len_rx;
                    csum_d = csum_q ^ byte_data;
                    if (len_rx == '0) begin
                        state_d = StCheck;
                    end else if (32'(len_rx) > MAX_WORDS) begin
                        state_d = StError;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (xfer) begin
                    csum_d = csum_q ^ byte_data;
                end
                if (pk_word_valid) begin
                    idx_d = idx_q + 1'b1;
                    if (idx_q == n_q - 1'b1) begin
                        state_d = StCheck;
                    end
                end
            end
            StCheck: begin
                if (xfer) begin
                    state_d = (byte_data == csum_q) ? StDone : StError;
                end
            end
            StDone:  state_d = StIdle;
            StError: ;
            default: state_d = StIdle;
        endcase

        // A transfer on the expiry cycle keeps the load alive.
        if (byte_ready && !xfer && (tmo_q + 32'd1 >= TIMEOUT_CYCLES)) begin
            state_d = StError;
        end

        if (start_load) begin
            state_d = StLenHi;
            idx_d   = '0;
            csum_d  = '0;
            tmo_d   = '0;
        end
    end

    always_comb begin
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (pk_word_valid) begin
            wr_addr_d = BaseAddr + (ADDR_WIDTH'(idx_q) << 2);
            wr_data_d = pk_word;
        end
    end

    always_ff @(posedge SYS_clk or negedge SYS_reset) begin
        if (!SYS_reset) begin
            state_q   <= StIdle;
            len_hi_q  <= '0;
            n_q       <= '0;
            idx_q     <= '0;
            csum_q    <= '0;
            tmo_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            len_hi_q  <= len_hi_d;
            n_q       <= n_d;
            idx_q     <= idx_d;
            csum_q    <= csum_d;
            tmo_q     <= tmo_d;
            wr_en_q   <= pk_word_valid;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign IMEM_wr_en   = wr_en_q;
    assign IMEM_wr_addr = wr_addr_q;
    assign IMEM_wr_data = wr_data_q;
    assign cpu_hold     = (state_q != StIdle);
    assign load_done    = (state_q == StDone);
    assign load_error   = (state_q == StError);

endmodule
